rx_decode_sm: RTL and testbench
===============================

RX_DECODE_SM -- requirements
Module: rx_decode_sm

Interface
REQ-001 clk  input  1  block clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 rx_block  input  66  descrambled block; [1:0] sync header, [9:2] block type, [65:10] payload.
REQ-004 r_type  input  3  class of rx_block from the upstream classifier: S=000, C=001, E=010, D=011, T=100; other codes are treated as E.
REQ-005 block_valid  input  1  rx_block/r_type carry a new block this cycle.
REQ-006 block_lock  input  1  block sync achieved.
REQ-007 hi_ber  input  1  high bit-error-rate indication.
REQ-008 cnt_clear  input  1  synchronous clear of err_cnt.
REQ-009 rxd  output  64  XGMII data; lane k = bits [8k+7:8k].
REQ-010 rxc  output  8  XGMII control flags; bit k = lane k.
REQ-011 rx_valid  output  1  one-cycle strobe: rxd/rxc updated.
REQ-012 err_cnt  output  8  count of blocks emitted as errored, saturating at 255.

Function
REQ-013 Each block_valid SHALL push rx_block/r_type into a one-block holding stage; the held block is CUR and the arriving block is NEXT.
REQ-014 The FSM SHALL advance and emit CUR only when block_valid=1 and the holding stage is full, so every emitted block sees its NEXT r_type.
REQ-015 rxd/rxc/rx_valid SHALL be registered; rx_valid SHALL pulse the cycle after the qualifying block_valid, giving a latency of one block plus one clk.
REQ-016 FSM states: RX_INIT, RX_C, RX_D, RX_T, RX_E; each evaluates CUR r_type and, for T, NEXT r_type.
REQ-017 Transitions from RX_INIT, RX_C and RX_T: C->RX_C, S->RX_D, otherwise RX_E.
REQ-018 Transitions from RX_D: D->RX_D; T with NEXT in {S,C} ->RX_T; otherwise RX_E.
REQ-019 Transitions from RX_E: D->RX_D; C->RX_C; T with NEXT in {S,C} ->RX_T; otherwise RX_E.
REQ-020 Output for RX_C, RX_D and RX_T SHALL be the XGMII decode of CUR.
- D: rxd=[65:2], rxc=00.
- C 0x1E: each 7-bit char, 0x00->0x07, else 0xFE; rxc=FF.
- C 0x4B: lane0=0x9C, lanes1-3=payload bytes, lanes4-7 decoded as for 0x1E; rxc=F1.
- S 0x78: lane0=0xFB, lanes1-7=payload; rxc=01.
- T types 0x87/99/AA/B4/CC/D2/E1/FF put 0xFD at lane 0..7 respectively, data bytes before it and 0x07 after it; rxc flags the 0xFD lane and every lane after it.
REQ-021 Output for RX_E SHALL be EBLOCK_R: all lanes 0xFE, rxc=FF.
REQ-022 Output for RX_INIT SHALL be LBLOCK_R: lane0=0x9C, lane3=0x01, other lanes 0x00, rxc=01.
REQ-023 When block_lock=0 or hi_ber=1, the FSM SHALL force RX_INIT and flush the holding stage.
- While either condition persists, it SHALL emit LBLOCK_R on each block_valid.
- This overrides all other transitions.
REQ-024 err_cnt SHALL increment by one per emitted EBLOCK_R and hold at 255.
REQ-025 cnt_clear SHALL zero err_cnt; a simultaneous increment is discarded.
REQ-026 With block_valid=0, state, holding stage and outputs SHALL hold, and rx_valid=0.

Reset
REQ-027 On rst_n=0:
- state = RX_INIT; holding stage empty;
- rxd = LBLOCK_R data, rxc = 01;
- rx_valid = 0; err_cnt = 0.
REQ-028 Reset asserted mid-packet SHALL discard CUR; the first block after release only fills the holding stage.

Structure
REQ-029 A shared PCS package SHALL hold:
- the r_type codes;
- block-type constants: 0x1E, 0x4B, 0x78, the T codes;
- XGMII characters: 0x07, 0xFE, 0xFB, 0xFD, 0x9C;
- the LBLOCK_R and EBLOCK_R constants;
- the FSM state encoding.
REQ-030 The block-to-XGMII decode SHALL be a combinational sub-module, rx_block_decode.

Verification
REQ-031 Idle stream: C 0x1E blocks, all chars 0x00 -> rxd all 0x07, rxc=FF, state RX_C, err_cnt=0.
REQ-032 Frame S, D x3, T 0xAA, C -> outputs, in order:
- 0xFB + data, rxc=01;
- three data blocks, rxc=00;
- two data bytes, 0xFD in lane2, 0x07 in lanes3-7, rxc=FC;
- idle block.
REQ-033 D then T 0x87 then D -> the T is emitted as EBLOCK_R (NEXT not S/C) and err_cnt=1.
REQ-034 block_lock dropped mid-frame -> next emitted block is LBLOCK_R (lane0 0x9C, lane3 0x01), state RX_INIT.
REQ-035 300 consecutive E blocks -> err_cnt saturates at 255; cnt_clear coincident with an increment -> 0.
REQ-036 rst_n asserted asynchronously mid-frame -> outputs are at reset values immediately, rx_valid stays 0 until the second post-reset block_valid.

Source files
------------

// File: rtl/rx_decode_sm_pkg.sv
// rx_decode_sm_pkg: shared PCS constants for 64b/66b receive decoding
package rx_decode_sm_pkg;

    localparam logic [2:0] R_S = 3'd0;
    localparam logic [2:0] R_C = 3'd1;
    localparam logic [2:0] R_E = 3'd2;
    localparam logic [2:0] R_D = 3'd3;
    localparam logic [2:0] R_T = 3'd4;

    localparam logic [7:0] BT_C = 8'h1E;
    localparam logic [7:0] BT_O = 8'h4B;
    localparam logic [7:0] BT_S = 8'h78;
    localparam logic [63:0] BT_T = {8'hFF, 8'hE1, 8'hD2, 8'hCC, 8'hB4, 8'hAA, 8'h99, 8'h87};

    localparam logic [7:0] XG_I = 8'h07;
    localparam logic [7:0] XG_E = 8'hFE;
    localparam logic [7:0] XG_S = 8'hFB;
    localparam logic [7:0] XG_T = 8'hFD;
    localparam logic [7:0] XG_O = 8'h9C;

    localparam logic [63:0] LBLOCK_D = 64'h0000_0000_0100_009C;
    localparam logic [7:0]  LBLOCK_C = 8'h01;
    localparam logic [63:0] EBLOCK_D = {8{XG_E}};
    localparam logic [7:0]  EBLOCK_C = 8'hFF;

    localparam logic [2:0] RX_INIT = 3'd0;
    localparam logic [2:0] RX_C    = 3'd1;
    localparam logic [2:0] RX_D    = 3'd2;
    localparam logic [2:0] RX_T    = 3'd3;
    localparam logic [2:0] RX_E    = 3'd4;

    function automatic logic [7:0] ctl_char(input logic [6:0] c);
        return c == 7'h00 ? XG_I : XG_E;
    endfunction

endpackage

// File: rtl/rx_block_decode.sv
// rx_block_decode: combinational decode of one 64b/66b block (header stripped) to XGMII
module rx_block_decode
    import rx_decode_sm_pkg::*;
(
    input  logic [63:0] blk,
    input  logic [2:0]  r_type,
    output logic [63:0] rxd,
    output logic [7:0]  rxc
);

    logic [63:0] p;

    assign p = {8'h00, blk[63:8]};

    // Map block type to lane characters; unrecognised control types decode as an error block
    always_comb begin
        rxd = EBLOCK_D;
        rxc = EBLOCK_C;
        if (r_type == R_D) begin
            rxd = blk;
            rxc = 8'h00;
        end else if (blk[7:0] == BT_C) begin
            for (int k = 0; k < 8; k++) rxd[8*k +: 8] = ctl_char(blk[8+7*k +: 7]);
        end else if (blk[7:0] == BT_O) begin
            rxd = {ctl_char(blk[57 +: 7]), ctl_char(blk[50 +: 7]), ctl_char(blk[43 +: 7]),
                   ctl_char(blk[36 +: 7]), p[23:0], XG_O};
            rxc = 8'hF1;
        end else if (blk[7:0] == BT_S) begin
            rxd = {p[55:0], XG_S};
            rxc = 8'h01;
        end else begin
            for (int n = 0; n < 8; n++) begin
                if (blk[7:0] == BT_T[8*n +: 8]) begin
                    for (int k = 0; k < 8; k++) rxd[8*k +: 8] = k < n ? p[8*k +: 8] : k == n ? XG_T : XG_I;
                    rxc = 8'hFF << n;
                end
            end
        end
    end

endmodule

// File: rtl/rx_decode_sm.sv
// rx_decode_sm: 64b/66b receive state machine with one-block lookahead and error counter
module rx_decode_sm
    import rx_decode_sm_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [65:0] rx_block,
    input  logic [2:0]  r_type,
    input  logic        block_valid,
    input  logic        block_lock,
    input  logic        hi_ber,
    input  logic        cnt_clear,
    output logic [63:0] rxd,
    output logic [7:0]  rxc,
    output logic        rx_valid,
    output logic [7:0]  err_cnt
);

    logic [2:0]  state, next_state, cur_type, nxt_type, from_ctl;
    logic [63:0] cur_block, dec_d;
    logic [7:0]  dec_c;
    logic        full, lost, t_ok, emit_err;
    logic        unused_hdr;

    assign unused_hdr = ^rx_block[1:0];
    assign lost       = !block_lock || hi_ber;
    assign nxt_type   = r_type > R_T ? R_E : r_type;
    assign emit_err   = block_valid && !lost && full && next_state == RX_E;

    rx_block_decode u_dec (
        .blk    (cur_block),
        .r_type (cur_type),
        .rxd    (dec_d),
        .rxc    (dec_c)
    );

    // Next state from CUR class, with NEXT class qualifying a terminate
    always_comb begin
        t_ok       = cur_type == R_T && (nxt_type == R_S || nxt_type == R_C);
        from_ctl   = cur_type == R_C ? RX_C : cur_type == R_S ? RX_D : RX_E;
        next_state = from_ctl;
        if (state == RX_D)
            next_state = cur_type == R_D ? RX_D : t_ok ? RX_T : RX_E;
        else if (state == RX_E)
            next_state = cur_type == R_D ? RX_D : cur_type == R_C ? RX_C : t_ok ? RX_T : RX_E;
    end

    // Holding stage, FSM state and registered XGMII outputs; loss of lock flushes everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_INIT;
            full      <= 1'b0;
            cur_block <= '0;
            cur_type  <= R_E;
            rxd       <= LBLOCK_D;
            rxc       <= LBLOCK_C;
            rx_valid  <= 1'b0;
        end else if (lost) begin
            state    <= RX_INIT;
            full     <= 1'b0;
            rx_valid <= block_valid;
            if (block_valid) begin
                rxd <= LBLOCK_D;
                rxc <= LBLOCK_C;
            end
        end else begin
            rx_valid <= block_valid && full;
            if (block_valid) begin
                cur_block <= rx_block[65:2];
                cur_type  <= nxt_type;
                full      <= 1'b1;
            end
            if (block_valid && full) begin
                state <= next_state;
                rxd   <= next_state == RX_E ? EBLOCK_D : dec_d;
                rxc   <= next_state == RX_E ? EBLOCK_C : dec_c;
            end
        end
    end

    // Saturating count of emitted error blocks; clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (cnt_clear)
            err_cnt <= 8'd0;
        else if (emit_err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end

endmodule

// File: tb/tb_rx_decode_sm.sv
// tb_rx_decode_sm: table vectors, corner sequences and randomized model check for rx_decode_sm
module tb_rx_decode_sm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [65:0] rx_block = '0;
    logic [2:0]  r_type = 3'd1;
    logic        block_valid = 1'b0;
    logic        block_lock = 1'b1;
    logic        hi_ber = 1'b0;
    logic        cnt_clear = 1'b0;
    logic [63:0] rxd;
    logic [7:0]  rxc;
    logic        rx_valid;
    logic [7:0]  err_cnt;

    rx_decode_sm dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_block    (rx_block),
        .r_type      (r_type),
        .block_valid (block_valid),
        .block_lock  (block_lock),
        .hi_ber      (hi_ber),
        .cnt_clear   (cnt_clear),
        .rxd         (rxd),
        .rxc         (rxc),
        .rx_valid    (rx_valid),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] LB   = 64'h0000_0000_0100_009C;
    localparam logic [63:0] EB   = 64'hFEFE_FEFE_FEFE_FEFE;
    localparam logic [63:0] I7   = 64'h0707_0707_0707_0707;
    localparam logic [63:0] SOUT = 64'h7766_5544_3322_11FB;
    localparam logic [63:0] TOUT = 64'h0707_0707_07FD_B2A1;
    localparam logic [65:0] IDLE = {56'h0, 8'h1E, 2'b10};
    localparam logic [65:0] SBLK = {56'h77_6655_4433_2211, 8'h78, 2'b10};
    localparam logic [65:0] D1   = {64'h1111_1111_1111_1111, 2'b01};
    localparam logic [65:0] D2   = {64'h2222_2222_2222_2222, 2'b01};
    localparam logic [65:0] D3   = {64'h3333_3333_3333_3333, 2'b01};
    localparam logic [65:0] TAA  = {56'h00_0000_0000_B2A1, 8'hAA, 2'b10};
    localparam logic [65:0] T87  = {56'h0, 8'h87, 2'b10};
    localparam logic [65:0] DX   = {64'hDEAD_BEEF_CAFE_F00D, 2'b01};
    localparam logic [65:0] DY   = {64'h0123_4567_89AB_CDEF, 2'b01};

    localparam int MI = 0, MC = 1, MD = 2, MT = 3, ME = 4;

    typedef struct {
        logic [65:0] blk;
        logic [2:0]  typ;
        logic        lk;
        logic        hb;
        logic        v;
        logic [63:0] d;
        logic [7:0]  c;
        logic [7:0]  err;
    } vec_t;

    vec_t tbl [24];
    logic [7:0] tcode [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

    int checks = 0;
    int errors = 0;

    int          m_st, m_err;
    logic        m_full, e_v;
    logic [65:0] m_blk;
    logic [2:0]  m_t;
    logic [63:0] e_d;
    logic [7:0]  e_c;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] cc(input logic [6:0] c);
        return c == 7'h00 ? 8'h07 : 8'hFE;
    endfunction

    // Reference decode built lane by lane from the block-format rules
    function automatic void mdec(input logic [65:0] b, input logic [2:0] t,
                                 output logic [63:0] d, output logic [7:0] c);
        logic [7:0]  l [8];
        logic [63:0] p;
        logic [7:0]  bt;
        int          n;
        p  = {8'h00, b[65:10]};
        bt = b[9:2];
        n  = -1;
        c  = 8'hFF;
        for (int k = 0; k < 8; k++) l[k] = 8'hFE;
        for (int k = 0; k < 8; k++) if (bt == tcode[k]) n = k;
        if (bt == 8'h1E) begin
            for (int k = 0; k < 8; k++) l[k] = cc(b[10+7*k +: 7]);
        end else if (bt == 8'h4B) begin
            l[0] = 8'h9C;
            for (int k = 1; k < 4; k++) l[k] = p[8*(k-1) +: 8];
            for (int k = 4; k < 8; k++) l[k] = cc(b[38+7*(k-4) +: 7]);
            c = 8'hF1;
        end else if (bt == 8'h78) begin
            l[0] = 8'hFB;
            for (int k = 1; k < 8; k++) l[k] = p[8*(k-1) +: 8];
            c = 8'h01;
        end else if (n >= 0) begin
            for (int k = 0; k < 8; k++) l[k] = k < n ? p[8*k +: 8] : (k == n ? 8'hFD : 8'h07);
            c = 8'hFF << n;
        end
        for (int k = 0; k < 8; k++) d[8*k +: 8] = l[k];
        if (t == 3'd3) begin
            d = b[65:2];
            c = 8'h00;
        end
    endfunction

    // Where CUR goes, organised by CUR class and previous state
    function automatic int next_st(input int st, input logic [2:0] cur, input logic [2:0] nxt);
        bit in_data = (st == MD) || (st == ME);
        bit nxt_ok  = (nxt == 3'd0) || (nxt == 3'd1);
        case (cur)
            3'd3:    return in_data ? MD : ME;
            3'd1:    return st == MD ? ME : MC;
            3'd0:    return in_data ? ME : MD;
            3'd4:    return (in_data && nxt_ok) ? MT : ME;
            default: return ME;
        endcase
    endfunction

    task automatic mreset();
        m_st = MI; m_full = 1'b0; m_err = 0; e_v = 1'b0; e_d = LB; e_c = 8'h01;
    endtask

    task automatic mstep(input logic [65:0] b, input logic [2:0] t, input logic lk, input logic hb, input logic clr);
        logic [2:0] tn;
        int         ns;
        tn = t > 3'd4 ? 3'd2 : t;
        if (!lk || hb) begin
            m_st = MI; m_full = 1'b0; e_v = 1'b1; e_d = LB; e_c = 8'h01;
        end else if (!m_full) begin
            m_full = 1'b1; m_blk = b; m_t = tn; e_v = 1'b0;
        end else begin
            ns = next_st(m_st, m_t, tn);
            if (ns == ME) begin
                e_d = EB; e_c = 8'hFF;
                if (m_err < 255) m_err++;
            end else begin
                mdec(m_blk, m_t, e_d, e_c);
            end
            m_st = ns; m_blk = b; m_t = tn; e_v = 1'b1;
        end
        if (clr) m_err = 0;
    endtask

    task automatic send(input logic [65:0] b, input logic [2:0] t, input logic lk, input logic hb, input logic clr);
        @(negedge clk);
        rx_block = b; r_type = t; block_lock = lk; hi_ber = hb; cnt_clear = clr; block_valid = 1'b1;
        mstep(b, t, lk, hb, clr);
        @(negedge clk);
        block_valid = 1'b0; block_lock = 1'b1; hi_ber = 1'b0; cnt_clear = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".rx_valid"}, 64'(rx_valid), 64'(e_v));
        chk({tag, ".rxd"}, rxd, e_d);
        chk({tag, ".rxc"}, 64'(rxc), 64'(e_c));
        chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mreset();
    endtask

    task automatic rand_blk(output logic [65:0] b, output logic [2:0] t);
        logic [63:0] r64;
        int          sel;
        r64 = {$urandom, $urandom};
        sel = $urandom_range(0, 9);
        if (sel <= 1) begin
            t = 3'd1;
            if ($urandom_range(0, 1) == 0) r64 = '0;
            b = {r64[55:0], ($urandom_range(0, 3) == 0) ? 8'h4B : 8'h1E, 2'b10};
        end else if (sel == 2) begin
            t = 3'd0; b = {r64[55:0], 8'h78, 2'b10};
        end else if (sel <= 5) begin
            t = 3'd3; b = {r64, 2'b01};
        end else if (sel <= 7) begin
            t = 3'd4; b = {r64[55:0], tcode[$urandom_range(0, 7)], 2'b10};
        end else begin
            t = (sel == 8) ? 3'd2 : 3'($urandom_range(5, 7));
            b = {r64[55:0], 8'h1E, 2'b10};
        end
    endtask

    initial begin
        logic [65:0] rb;
        logic [2:0]  rt;
        mreset();
        repeat (2) @(negedge clk);
        chk("reset.rxd", rxd, LB);
        chk("reset.rxc", 64'(rxc), 64'h01);
        chk("reset.rx_valid", 64'(rx_valid), 64'h0);
        chk("reset.err_cnt", 64'(err_cnt), 64'h0);
        rst_n = 1'b1;

        tbl[0]  = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b0, LB, 8'h01, 8'd0};
        tbl[1]  = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd0};
        tbl[2]  = '{SBLK, 3'd0, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd0};
        tbl[3]  = '{D1,   3'd3, 1'b1, 1'b0, 1'b1, SOUT, 8'h01, 8'd0};
        tbl[4]  = '{D2,   3'd3, 1'b1, 1'b0, 1'b1, 64'h1111_1111_1111_1111, 8'h00, 8'd0};
        tbl[5]  = '{D3,   3'd3, 1'b1, 1'b0, 1'b1, 64'h2222_2222_2222_2222, 8'h00, 8'd0};
        tbl[6]  = '{TAA,  3'd4, 1'b1, 1'b0, 1'b1, 64'h3333_3333_3333_3333, 8'h00, 8'd0};
        tbl[7]  = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, TOUT, 8'hFC, 8'd0};
        tbl[8]  = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd0};
        tbl[9]  = '{SBLK, 3'd0, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd0};
        tbl[10] = '{DX,   3'd3, 1'b1, 1'b0, 1'b1, SOUT, 8'h01, 8'd0};
        tbl[11] = '{T87,  3'd4, 1'b1, 1'b0, 1'b1, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, 8'd0};
        tbl[12] = '{DY,   3'd3, 1'b1, 1'b0, 1'b1, EB, 8'hFF, 8'd1};
        tbl[13] = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 8'h00, 8'd1};
        tbl[14] = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, EB, 8'hFF, 8'd2};
        tbl[15] = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd2};
        tbl[16] = '{SBLK, 3'd0, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd2};
        tbl[17] = '{DX,   3'd3, 1'b1, 1'b0, 1'b1, SOUT, 8'h01, 8'd2};
        tbl[18] = '{DY,   3'd3, 1'b0, 1'b0, 1'b1, LB, 8'h01, 8'd2};
        tbl[19] = '{DY,   3'd3, 1'b1, 1'b0, 1'b0, LB, 8'h01, 8'd2};
        tbl[20] = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, EB, 8'hFF, 8'd3};
        tbl[21] = '{IDLE, 3'd1, 1'b1, 1'b1, 1'b1, LB, 8'h01, 8'd3};
        tbl[22] = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b0, LB, 8'h01, 8'd3};
        tbl[23] = '{IDLE, 3'd1, 1'b1, 1'b0, 1'b1, I7, 8'hFF, 8'd3};

        for (int i = 0; i < 24; i++) begin
            send(tbl[i].blk, tbl[i].typ, tbl[i].lk, tbl[i].hb, 1'b0);
            chk($sformatf("tbl%0d.rx_valid", i), 64'(rx_valid), 64'(tbl[i].v));
            chk($sformatf("tbl%0d.rxd", i), rxd, tbl[i].d);
            chk($sformatf("tbl%0d.rxc", i), 64'(rxc), 64'(tbl[i].c));
            chk($sformatf("tbl%0d.err_cnt", i), 64'(err_cnt), 64'(tbl[i].err));
        end

        do_reset();
        send(IDLE, 3'd1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) send(IDLE | 66'h3FC00, (i % 2 == 0) ? 3'd2 : 3'd7, 1'b1, 1'b0, 1'b0);
        chk("sat.err_cnt", 64'(err_cnt), 64'd255);
        chk_model("sat");
        send(IDLE, 3'd2, 1'b1, 1'b0, 1'b1);
        chk("clr_inc.err_cnt", 64'(err_cnt), 64'd0);
        send(IDLE, 3'd2, 1'b1, 1'b0, 1'b0);
        chk("after_clr.err_cnt", 64'(err_cnt), 64'd1);

        do_reset();
        send(IDLE, 3'd1, 1'b1, 1'b0, 1'b0);
        send(SBLK, 3'd0, 1'b1, 1'b0, 1'b0);
        send(D1, 3'd3, 1'b1, 1'b0, 1'b0);
        send(IDLE, 3'd2, 1'b1, 1'b0, 1'b0);
        send(D2, 3'd3, 1'b1, 1'b0, 1'b0);
        chk("pre_arst.err_cnt", 64'(err_cnt), 64'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.rxd", rxd, LB);
        chk("arst.rxc", 64'(rxc), 64'h01);
        chk("arst.rx_valid", 64'(rx_valid), 64'h0);
        chk("arst.err_cnt", 64'(err_cnt), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        mreset();
        send(D3, 3'd3, 1'b1, 1'b0, 1'b0);
        chk("arst_first.rx_valid", 64'(rx_valid), 64'h0);
        send(IDLE, 3'd1, 1'b1, 1'b0, 1'b0);
        chk("arst_second.rx_valid", 64'(rx_valid), 64'h1);
        chk("arst_second.rxd", rxd, EB);

        do_reset();
        for (int i = 0; i < 600; i++) begin
            rand_blk(rb, rt);
            send(rb, rt, $urandom_range(0, 39) != 0, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
            chk_model($sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
